// File: rtl/pll_phase_pkg.sv
// Shared definitions for the PLL dynamic-phase stepper.
//   state_t          : controller states
//   PHASESEL_C0..C3  : PHASESEL pin encoding for each steppable PLL output
//   ch_to_phasesel() : maps a request channel number onto the PHASESEL encoding
package pll_phase_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STEP_LO,
        STEP_HI,
        RELOCK,
        FINISH
    } state_t;

    localparam logic [1:0] PHASESEL_C0 = 2'd0;
    localparam logic [1:0] PHASESEL_C1 = 2'd1;
    localparam logic [1:0] PHASESEL_C2 = 2'd2;
    localparam logic [1:0] PHASESEL_C3 = 2'd3;

    // PHASESEL/PHASEDIR must be settled this many clocks before the first pulse
    localparam int SETUP_CYCLES = 2;

    // Width of each per-channel phase offset accumulator
    localparam int PHASE_OFS_W = 16;

    function automatic logic [1:0] ch_to_phasesel(input logic [1:0] ch);
        logic [1:0] sel;
        case (ch)
            2'd0:    sel = PHASESEL_C0;
            2'd1:    sel = PHASESEL_C1;
            2'd2:    sel = PHASESEL_C2;
            default: sel = PHASESEL_C3;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// PLL lock synchroniser and qualification filter.
// The raw LOCK pin is double-flopped; locked_q rises once the synchronised
// lock has been high for LOCK_FILTER consecutive clocks (on the following
// clock) and drops the clock after any synchronised low.
// Ports:
//   clock      in  system clock
//   reset      in  synchronous active-high reset
//   pll_locked in  raw asynchronous PLL LOCK
//   locked_q   out qualified lock
module pll_lock_filter #(
    parameter int LOCK_FILTER = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic pll_locked,
    output logic locked_q
);

    localparam int CNT_W = $clog2(LOCK_FILTER + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_FILTER);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    // Stage p0/p1: metastability synchroniser
    always_ff @(posedge clock) begin
        sync_p0 <= pll_locked;
        sync_p1 <= sync_p0;
    end

    // Filter: count saturates at LOCK_FILTER, qualification follows one clock later
    always_ff @(posedge clock) begin
        if (reset || !sync_p1) begin
            cnt      <= '0;
            locked_q <= 1'b0;
        end else begin
            if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            locked_q <= (cnt == CNT_MAX);
        end
    end

endmodule

// File: rtl/pll_phase_stepper.sv
// PLL dynamic phase-shift stepper.
// Accepts a (channel, direction, step count) request and drives the PLL
// dynamic-phase pins: PHASESEL/PHASEDIR are set up, then PHASESTEP is pulsed
// low req_steps times (PULSE_CYCLES low, SETTLE_CYCLES high), after which the
// controller waits for qualified lock and reports done. Loss of lock while
// stepping aborts the sequence with an error pulse; done still follows relock.
// An out-of-range channel is accepted but only answered with an error pulse.
// Optional feature macro PLL_PHASE_TRACK_EN adds the phase_ofs output:
// a signed 16-bit running phase offset per channel (wraps modulo 2^16).
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   pll_locked              raw PLL LOCK (asynchronous)
//   req_valid/req_ready     request handshake
//   req_ch/req_dir/req_steps  channel, direction (1 = up), step count
//   busy                    high in every state except IDLE
//   done, error             single-clock completion / failure pulses
//   locked_q                filtered lock
//   phasesel, phasedir, phasestep, phaseloadreg  PLL dynamic-phase pins
//   phase_ofs               (PLL_PHASE_TRACK_EN only) NUM_CH x 16-bit offsets
module pll_phase_stepper
    import pll_phase_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int STEP_W        = 8,
    parameter int PULSE_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int LOCK_FILTER   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pll_locked,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_ch,
    input  logic              req_dir,
    input  logic [STEP_W-1:0] req_steps,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              locked_q,
    output logic [1:0]        phasesel,
    output logic              phasedir,
    output logic              phasestep,
    output logic              phaseloadreg
`ifdef PLL_PHASE_TRACK_EN
    ,
    output logic [NUM_CH*PHASE_OFS_W-1:0] phase_ofs
`endif
);

    localparam int TMR_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + SETUP_CYCLES);
    localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(SETUP_CYCLES - 1);
    localparam logic [TMR_W-1:0] LO_LAST    = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HI_LAST    = TMR_W'(SETTLE_CYCLES - 1);

    state_t            state;
    state_t            state_nx;
    logic [TMR_W-1:0]  tmr;
    logic [STEP_W-1:0] rem;
    logic              bad;
    logic              ch_bad;
    logic              accept;

    pll_lock_filter #(
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock (
        .clock      (clock),
        .reset      (reset),
        .pll_locked (pll_locked),
        .locked_q   (locked_q)
    );

    assign phaseloadreg = 1'b1;
    assign ch_bad       = (32'(req_ch) >= NUM_CH);
    assign accept       = (state == IDLE) && req_valid && locked_q;

    // Next state and pin/status decode
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        phasestep = 1'b1;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = locked_q;
                if (req_valid && locked_q) begin
                    // An invalid channel skips straight to FINISH, which reports it as an error
                    state_nx = ch_bad ? FINISH : SETUP;
                end
            end
            SETUP: begin
                if (!locked_q) begin
                    state_nx = RELOCK;
                    error    = 1'b1;
                end else if (tmr == SETUP_LAST) begin
                    state_nx = (rem == '0) ? FINISH : STEP_LO;
                end
            end
            STEP_LO: begin
                phasestep = 1'b0;
                if (!locked_q) begin
                    state_nx = RELOCK;
                    error    = 1'b1;
                end else if (tmr == LO_LAST) begin
                    state_nx = STEP_HI;
                end
            end
            STEP_HI: begin
                if (!locked_q) begin
                    state_nx = RELOCK;
                    error    = 1'b1;
                end else if (tmr == HI_LAST) begin
                    state_nx = (rem != '0) ? STEP_LO : RELOCK;
                end
            end
            RELOCK: begin
                if (locked_q) begin
                    state_nx = FINISH;
                end
            end
            FINISH: begin
                state_nx = IDLE;
                if (bad) begin
                    error = 1'b1;
                end else begin
                    done = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Phase timer restarts on every state change; step count drops on each STEP_LO entry
    always_ff @(posedge clock) begin
        tmr <= (state_nx != state) ? '0 : tmr + 1'b1;
        if (accept) begin
            rem <= req_steps;
            bad <= ch_bad;
        end else if ((state_nx == STEP_LO) && (state != STEP_LO)) begin
            rem <= rem - 1'b1;
        end
    end

    // Pin selection only changes on a valid accept, so it holds through FINISH
    always_ff @(posedge clock) begin
        if (reset) begin
            phasesel <= PHASESEL_C0;
            phasedir <= 1'b0;
        end else if (accept && !ch_bad) begin
            phasesel <= ch_to_phasesel(req_ch);
            phasedir <= req_dir;
        end
    end

`ifdef PLL_PHASE_TRACK_EN
    logic signed [PHASE_OFS_W-1:0] ofs [NUM_CH];
    logic                          pulse_done;

    function automatic logic signed [PHASE_OFS_W-1:0] step_ofs(
        input logic signed [PHASE_OFS_W-1:0] cur,
        input logic                          up
    );
        // Plain two's-complement wrap, no saturation
        return up ? cur + 16'sd1 : cur - 16'sd1;
    endfunction

    // A pulse counts only when its full low time completed under lock
    assign pulse_done = (state == STEP_LO) && (state_nx == STEP_HI);

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                ofs[i] <= '0;
            end else if (pulse_done && (phasesel == ch_to_phasesel(i[1:0]))) begin
                ofs[i] <= step_ofs(ofs[i], phasedir);
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ofs
        assign phase_ofs[g*PHASE_OFS_W +: PHASE_OFS_W] = ofs[g];
    end
`endif

endmodule
